// File: rtl/vga_dump_if.sv
// Read-port bundle between the dump sequencer and the shared register/memory
// debug port (request/grant handshake followed by a one-cycle data strobe).
interface vga_dump_if #(
    parameter int ADDR_W = 5
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_gnt;
    logic              rd_valid;
    logic [15:0]       rd_data;

    modport master (
        output rd_req,
        output rd_addr,
        input  rd_gnt,
        input  rd_valid,
        input  rd_data
    );

    modport slave (
        input  rd_req,
        input  rd_addr,
        output rd_gnt,
        output rd_valid,
        output rd_data
    );
endinterface

// File: rtl/vga_dump_sequencer.sv
// Once every FRAME_DIV vertical syncs, fetches NUM_WORDS words (highest address
// first) from the shared read port and shifts each into the VGA dump display.
module vga_dump_sequencer #(
    parameter int NUM_WORDS = 18,
    parameter int ADDR_W    = 5,
    parameter int FRAME_DIV = 1,
    parameter bit VSYNC_POL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        v_sync_i,
    input  logic        freeze_i,
    vga_dump_if.master  rd,
    output logic [15:0] data_o,
    output logic        en_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        overrun_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_PUSH
    } state_t;

    localparam logic              SYNC_IDLE  = !VSYNC_POL;
    localparam logic [7:0]        FRAME_LAST = 8'(FRAME_DIV - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(NUM_WORDS - 1);

    // [0],[1] synchroniser stages; [2] previous value of stage [1] for the edge.
    logic [2:0]        sync_q;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic              sync_edge;
    logic              trigger;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic              rd_req_q;
    logic [15:0]       data_q;
    logic              en_q;
    logic              busy_q;
    logic              done_q;
    logic              overrun_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= {3{SYNC_IDLE}};
            frame_cnt_q <= '0;
        end else begin
            sync_q      <= {sync_q[1:0], v_sync_i};
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign sync_edge = (sync_q[1] == VSYNC_POL) && (sync_q[2] != VSYNC_POL);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        trigger     = 1'b0;
        if (sync_edge) begin
            if (frame_cnt_q == FRAME_LAST) begin
                frame_cnt_d = '0;
                trigger     = 1'b1;
            end else begin
                frame_cnt_d = frame_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            rd_req_q  <= 1'b0;
            data_q    <= '0;
            en_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            en_q   <= 1'b0;
            done_q <= 1'b0;
            // Any trigger outside IDLE, including the final PUSH cycle, is an overrun.
            if (trigger && state_q != ST_IDLE) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (trigger && !freeze_i) begin
                        addr_q   <= ADDR_LAST;
                        rd_req_q <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (rd.rd_gnt) begin
                        rd_req_q <= 1'b0;
                        state_q  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (rd.rd_valid) begin
                        data_q  <= rd.rd_data;
                        en_q    <= 1'b1;
                        done_q  <= (addr_q == '0);
                        state_q <= ST_PUSH;
                    end
                end
                ST_PUSH: begin
                    if (addr_q == '0) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        addr_q   <= addr_q - 1'b1;
                        rd_req_q <= 1'b1;
                        state_q  <= ST_REQ;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rd.rd_req  = rd_req_q;
    assign rd.rd_addr = addr_q;
    assign data_o     = data_q;
    assign en_o       = en_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_vga_dump_sequencer.sv
// Randomised scoreboard bench for vga_dump_sequencer: a read-port responder,
// a frame-level reference model and a decoupled monitor on the en strobe.
module tb_vga_dump_sequencer;

    localparam int NUM_WORDS = 18;
    localparam int ADDR_W    = 5;
    localparam int FRAME_DIV = 3;
    localparam bit VSYNC_POL = 1'b1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        v_sync = !VSYNC_POL;
    logic        freeze = 1'b0;
    logic [15:0] data;
    logic        en, busy, done, overrun;

    vga_dump_if #(.ADDR_W(ADDR_W)) rd ();

    vga_dump_sequencer #(
        .NUM_WORDS(NUM_WORDS),
        .ADDR_W   (ADDR_W),
        .FRAME_DIV(FRAME_DIV),
        .VSYNC_POL(VSYNC_POL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .v_sync_i (v_sync),
        .freeze_i (freeze),
        .rd       (rd.master),
        .data_o   (data),
        .en_o     (en),
        .busy_o   (busy),
        .done_o   (done),
        .overrun_o(overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame-level view of which sync pulses start a refresh.
    logic [15:0] exp_q[$];
    bit          model_busy   = 1'b0;
    bit          exp_overrun  = 1'b0;
    int          pulse_cnt    = 0;
    int          en_cnt       = 0;
    bit          busy_low_due = 1'b0;

    // Responder configuration and state.
    logic [15:0] base      = 16'hA000;
    int          gnt_delay = 0;
    int          stall_addr = -1;
    int          stall_len = 0;
    int          lat_min   = 1;
    int          lat_max   = 1;
    bit          noise     = 1'b0;
    bit          pending   = 1'b0;
    bit          valid_is_real = 1'b0;
    int          wait_cnt  = 0;
    int          hold      = 0;
    int          lat_cnt   = 0;
    logic [ADDR_W-1:0] req_addr;
    logic [ADDR_W-1:0] p_addr;

    // Shared read port: grants after a configurable delay, returns base+addr.
    initial begin
        rd.rd_gnt   = 1'b0;
        rd.rd_valid = 1'b0;
        rd.rd_data  = '0;
        forever begin
            @(negedge clk);
            rd.rd_gnt     = 1'b0;
            rd.rd_valid   = 1'b0;
            valid_is_real = 1'b0;
            rd.rd_data    = 16'($urandom);
            if (pending) begin
                if (lat_cnt == 0) begin
                    rd.rd_valid   = 1'b1;
                    valid_is_real = 1'b1;
                    rd.rd_data    = base + 16'(p_addr);
                    pending       = 1'b0;
                end else begin
                    lat_cnt--;
                end
            end else if (!rst && (rd.rd_req || wait_cnt > 0)) begin
                if (wait_cnt == 0) begin
                    req_addr = rd.rd_addr;
                    hold     = (int'(rd.rd_addr) == stall_addr) ? stall_len : gnt_delay;
                end else begin
                    check("req_held", 32'(rd.rd_req), 32'd1);
                    check("addr_held", 32'(rd.rd_addr), 32'(req_addr));
                end
                if (wait_cnt < hold) begin
                    wait_cnt++;
                end else begin
                    rd.rd_gnt = 1'b1;
                    wait_cnt  = 0;
                    pending   = 1'b1;
                    p_addr    = req_addr;
                    lat_cnt   = $urandom_range(lat_max, lat_min) - 1;
                end
            end
            if (noise && !pending && !rd.rd_valid && ($urandom_range(5, 0) == 0)) begin
                rd.rd_valid = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard on every en strobe.
    initial begin
        logic [15:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                busy_low_due = 1'b0;
                continue;
            end
            if (busy_low_due) begin
                check("busy_after_done", 32'(busy), 32'd0);
                busy_low_due = 1'b0;
            end
            if (done) check("done_with_en", 32'(en), 32'd1);
            if (en) begin
                en_cnt++;
                check("en_after_valid", 32'(valid_is_real), 32'd1);
                if (exp_q.size() == 0) begin
                    check("unexpected_en", 32'(en), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("word", 32'(data), 32'(e));
                    check("done_flag", 32'(done), 32'(exp_q.size() == 0));
                    if (exp_q.size() == 0) begin
                        model_busy   = 1'b0;
                        busy_low_due = 1'b1;
                    end
                end
            end
        end
    end

    task automatic pulse(input int hi, input int lo);
        bit trig, start, was_busy;
        @(negedge clk);
        pulse_cnt++;
        was_busy = model_busy;
        trig     = (pulse_cnt % FRAME_DIV) == 0;
        start    = trig && !model_busy && !freeze;
        if (trig && model_busy) exp_overrun = 1'b1;
        if (start) begin
            model_busy = 1'b1;
            for (int a = NUM_WORDS - 1; a >= 0; a--) exp_q.push_back(base + 16'(a));
        end
        v_sync = VSYNC_POL;
        if (!was_busy) begin
            repeat (2) @(negedge clk);
            check("req_early", 32'(rd.rd_req), 32'd0);
            @(negedge clk);
            check("req_start", 32'(rd.rd_req), 32'(start));
            check("busy_start", 32'(busy), 32'(start));
            if (start) check("addr_start", 32'(rd.rd_addr), 32'(NUM_WORDS - 1));
            repeat (hi - 3) @(negedge clk);
        end else begin
            repeat (hi) @(negedge clk);
        end
        v_sync = !VSYNC_POL;
        repeat (lo) @(negedge clk);
    endtask

    task automatic run_to_trigger(input int lo);
        while (((pulse_cnt + 1) % FRAME_DIV) != 0) pulse(4, 10);
        pulse(4, lo);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((model_busy || exp_q.size() != 0) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) begin
            check("sequence_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            model_busy = 1'b0;
        end
        repeat (4) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_req", 32'(rd.rd_req), 32'd0);
        check("overrun", 32'(overrun), 32'(exp_overrun));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_req"}, 32'(rd.rd_req), 32'd0);
        check({tag, "_rd_addr"}, 32'(rd.rd_addr), 32'd0);
        check({tag, "_data"}, 32'(data), 32'd0);
        check({tag, "_en"}, 32'(en), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_overrun"}, 32'(overrun), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        int t;
        #2;
        check_all_zero("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Basic refresh: immediate grant, one-cycle read latency.
        base = 16'hA000;
        run_to_trigger(20);
        wait_idle();

        // Frame divide: 7 pulses, refreshes on pulses 6 and 9 of the running count
        // (3rd and 6th of this group since the count is a multiple of 3 here).
        base = 16'h3000;
        for (int i = 0; i < 7; i++) pulse(4, 120);
        wait_idle();

        // Arbitration stall on address 5 with 3-cycle read latency.
        stall_addr = 5; stall_len = 10; lat_min = 3; lat_max = 3;
        base = 16'h5000;
        run_to_trigger(20);
        wait_idle();
        stall_addr = -1; lat_min = 1; lat_max = 1;

        // Frozen trigger starts nothing.
        freeze = 1'b1;
        run_to_trigger(20);
        freeze = 1'b0;
        wait_idle();

        // Busy trigger with a long first grant; freeze mid-sequence must not abort.
        stall_addr = 17; stall_len = 1000;
        base = 16'h7000;
        run_to_trigger(5);
        freeze = 1'b1;
        for (int i = 0; i < FRAME_DIV; i++) pulse(4, 10);
        freeze = 1'b0;
        stall_addr = -1;
        wait_idle();

        // Randomised grant delay, read latency and stray strobes; overrun stays set.
        noise = 1'b1;
        for (int k = 0; k < 4; k++) begin
            gnt_delay = $urandom_range(3, 0);
            lat_min   = 1;
            lat_max   = $urandom_range(4, 1);
            base      = {4'($urandom_range(15, 0)), 12'h000};
            run_to_trigger(20);
            wait_idle();
        end
        noise = 1'b0; gnt_delay = 0; lat_min = 1; lat_max = 1;

        // Reset after the 7th en of a sequence.
        base   = 16'h9000;
        en_cnt = 0;
        run_to_trigger(2);
        t = 0;
        while (en_cnt < 7 && t < 2000) begin
            @(posedge clk);
            #2;
            t++;
        end
        check("reach_7th_en", 32'(en_cnt), 32'd7);
        #2;
        rst = 1'b1;
        exp_q.delete();
        model_busy  = 1'b0;
        exp_overrun = 1'b0;
        pulse_cnt   = 0;
        wait_cnt    = 0;
        #1;
        check_all_zero("midreset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        base = 16'hC000;
        run_to_trigger(20);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
